// File: rtl/alu_pkg.sv
// Shared decode/ALU definitions: opcodes, instruction field positions,
// shift-control encodings and NZCV bit indices.
package alu_pkg;
  localparam int DATA_W   = 32;
  localparam int REG_W    = 4;
  localparam int NUM_REGS = 16;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_MUL    = 4'b0010;
  localparam logic [3:0] OP_OR     = 4'b0011;
  localparam logic [3:0] OP_AND    = 4'b0100;
  localparam logic [3:0] OP_XOR    = 4'b0101;
  localparam logic [3:0] OP_MOVN   = 4'b0110;
  localparam logic [3:0] OP_MOVREG = 4'b0111;
  localparam logic [3:0] OP_CMP    = 4'b1000;
  localparam logic [3:0] OP_LDR    = 4'b1001;
  localparam logic [3:0] OP_STR    = 4'b1010;
  localparam logic [3:0] OP_NOP    = 4'b1111;

  localparam int COND_HI = 31, COND_LO = 28;
  localparam int OPC_HI  = 27, OPC_LO  = 24;
  localparam int SBIT    = 23;
  localparam int SRC_HI  = 22, SRC_LO  = 20;
  localparam int RD_HI   = 19, RD_LO   = 16;
  localparam int RN_HI   = 15, RN_LO   = 12;
  localparam int RM_HI   = 11, RM_LO   = 8;
  localparam int IMM_HI  = 15, IMM_LO  = 0;

  localparam logic [2:0] SR_NONE = 3'b000;
  localparam logic [2:0] SR_LSL  = 3'b001;
  localparam logic [2:0] SR_LSR  = 3'b010;
  localparam logic [2:0] SR_ASR  = 3'b011;
  localparam logic [2:0] SR_ROR  = 3'b100;

  localparam int FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0;

  typedef struct packed {
    logic [3:0]        opcode;
    logic              use_rn;
    logic              use_rm;
    logic              wb_en;
  } dec_t;

  typedef struct packed {
    logic [3:0]        cond;
    logic [3:0]        opcode;
    logic              sbit;
    logic [2:0]        srcontrol;
    logic [15:0]       imvalue;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [REG_W-1:0]  rd;
    logic              wb_en;
  } ex_slot_t;

  // Undefined opcodes collapse to NOP so the ALU never sees them.
  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    d.opcode = op;
    d.use_rn = 1'b0;
    d.use_rm = 1'b0;
    d.wb_en  = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        d.use_rn = 1'b1; d.use_rm = 1'b1; d.wb_en = 1'b1;
      end
      OP_CMP, OP_STR:    begin d.use_rn = 1'b1; d.use_rm = 1'b1; end
      OP_MOVN:           d.wb_en = 1'b1;
      OP_MOVREG, OP_LDR: begin d.use_rn = 1'b1; d.wb_en = 1'b1; end
      OP_NOP:            d.opcode = OP_NOP;
      default:           d.opcode = OP_NOP;
    endcase
    return d;
  endfunction
endpackage

// File: rtl/decode_stage_if.sv
// Instruction, ALU-slot, writeback and flag signals of the decode stage.
interface decode_stage_if;
  import alu_pkg::*;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_cond;
  logic [3:0]        ex_opcode;
  logic              ex_sbit;
  logic [2:0]        ex_srcontrol;
  logic [15:0]       ex_imvalue;
  logic [DATA_W-1:0] ex_in1;
  logic [DATA_W-1:0] ex_in2;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_wb_en;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flag_we;
  logic [3:0]        alu_flags;
  logic [3:0]        nzcv;

  modport master (
    output instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data, flag_we, alu_flags,
    input  instr_ready, ex_valid, ex_cond, ex_opcode, ex_sbit, ex_srcontrol,
           ex_imvalue, ex_in1, ex_in2, ex_rd, ex_wb_en, nzcv
  );
  modport slave (
    input  instr_valid, instr, ex_ready, wb_valid, wb_rd, wb_data, flag_we, alu_flags,
    output instr_ready, ex_valid, ex_cond, ex_opcode, ex_sbit, ex_srcontrol,
           ex_imvalue, ex_in1, ex_in2, ex_rd, ex_wb_en, nzcv
  );
endinterface

// File: rtl/decode_stage_reg_file.sv
// 16x32 register file: two combinational read ports, one write port,
// same-cycle write data forwarded to matching reads.
module reg_file
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_W-1:0]  raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_W-1:0]  raddr2,
  output logic [DATA_W-1:0] rdata2
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  regs <= '0;
    else if (we) regs[waddr] <= wdata;
  end

  assign rdata1 = (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/decode_stage.sv
// Decode/operand-fetch stage: splits the instruction, reads operands, tracks
// pending destinations for RAW stalls and holds the result in the ALU slot.
module decode_stage
  import alu_pkg::*;
(
  input logic          clk,
  input logic          reset,
  decode_stage_if.slave bus
);
  logic [NUM_REGS-1:0] pending, pending_nxt;
  logic [REG_W-1:0]    rd, rn, rm;
  logic [DATA_W-1:0]   rdata1, rdata2;
  logic                byp_rn, byp_rm, hazard, slot_free, transfer;
  logic                ex_valid;
  logic [3:0]          nzcv;
  ex_slot_t            slot;
  dec_t                dec;

  assign rd  = bus.instr[RD_HI:RD_LO];
  assign rn  = bus.instr[RN_HI:RN_LO];
  assign rm  = bus.instr[RM_HI:RM_LO];
  assign dec = decode_op(bus.instr[OPC_HI:OPC_LO]);

  reg_file u_rf (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.wb_valid),
    .waddr  (bus.wb_rd),
    .wdata  (bus.wb_data),
    .raddr1 (rn),
    .rdata1 (rdata1),
    .raddr2 (rm),
    .rdata2 (rdata2)
  );

  // A retiring writeback to a pending source clears the hazard; the read
  // port forwards its data in the same cycle.
  assign byp_rn    = bus.wb_valid && bus.wb_rd == rn;
  assign byp_rm    = bus.wb_valid && bus.wb_rd == rm;
  assign hazard    = (dec.use_rn && pending[rn] && !byp_rn) ||
                     (dec.use_rm && pending[rm] && !byp_rm);
  assign slot_free = !ex_valid || bus.ex_ready;
  assign bus.instr_ready = slot_free && !hazard;
  assign transfer  = bus.instr_valid && bus.instr_ready;

  // Set after clear so a new writer of the retiring register stays pending.
  always_comb begin
    pending_nxt = pending;
    if (bus.wb_valid)           pending_nxt[bus.wb_rd] = 1'b0;
    if (transfer && dec.wb_en)  pending_nxt[rd]        = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      slot     <= '0;
    end else if (transfer) begin
      ex_valid       <= 1'b1;
      slot.cond      <= bus.instr[COND_HI:COND_LO];
      slot.opcode    <= dec.opcode;
      slot.sbit      <= bus.instr[SBIT];
      slot.srcontrol <= bus.instr[SRC_HI:SRC_LO];
      slot.imvalue   <= bus.instr[IMM_HI:IMM_LO];
      slot.in1       <= rdata1;
      slot.in2       <= rdata2;
      slot.rd        <= rd;
      slot.wb_en     <= dec.wb_en;
    end else if (slot_free) begin
      ex_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           nzcv <= '0;
    else if (bus.flag_we) nzcv <= bus.alu_flags;
  end

  assign bus.ex_valid     = ex_valid;
  assign bus.ex_cond      = slot.cond;
  assign bus.ex_opcode    = slot.opcode;
  assign bus.ex_sbit      = slot.sbit;
  assign bus.ex_srcontrol = slot.srcontrol;
  assign bus.ex_imvalue   = slot.imvalue;
  assign bus.ex_in1       = slot.in1;
  assign bus.ex_in2       = slot.in2;
  assign bus.ex_rd        = slot.rd;
  assign bus.ex_wb_en     = slot.wb_en;
  assign bus.nzcv         = nzcv;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ALU-slot contents are queued at
// issue and compared by a monitor whenever the slot is consumed.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus();
  decode_stage dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  opc;
    logic        sbit;
    logic [2:0]  src;
    logic [15:0] imm;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [3:0]  rd;
    logic        wb;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [3:0] opc,
                              input logic [31:0] a, input logic [31:0] b, input logic wb);
    exp_t e;
    e.cond = w[31:28]; e.opc = opc; e.sbit = w[23]; e.src = w[22:20];
    e.imm = w[15:0]; e.in1 = a; e.in2 = b; e.rd = w[19:16]; e.wb = wb;
    return e;
  endfunction

  // Monitor: every consumed slot must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && bus.ex_valid && bus.ex_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL slot_unexpected actual opcode=%0h rd=%0h required no slot", bus.ex_opcode, bus.ex_rd);
      end else begin
        exp_t e;
        logic [96:0] act, req;
        e = q.pop_front();
        act = {bus.ex_cond, bus.ex_opcode, bus.ex_sbit, bus.ex_srcontrol, bus.ex_imvalue,
               bus.ex_in1, bus.ex_in2, bus.ex_rd, bus.ex_wb_en};
        req = {e.cond, e.opc, e.sbit, e.src, e.imm, e.in1, e.in2, e.rd, e.wb};
        if (act !== req) begin
          errors++;
          $display("FAIL slot_contents actual=%h required=%h", act, req);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [3:0] r, input logic [31:0] d);
    bus.wb_valid = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    tick();
    bus.wb_valid = 1'b0;
  endtask

  // Issue one instruction, waiting (bounded) for instr_ready.
  task automatic send(input logic [31:0] w, input exp_t e, output int waited);
    bus.instr_valid = 1'b1; bus.instr = w;
    waited = 0;
    @(negedge clk);
    while (!bus.instr_ready && waited < 20) begin
      tick(); waited++;
      @(negedge clk);
    end
    if (bus.instr_ready) q.push_back(e);
    else begin
      checks++; errors++;
      $display("FAIL issue_timeout actual instr_ready=0 required 1 instr=%h", w);
    end
    tick();
    bus.instr_valid = 1'b0;
  endtask

  // Dependent instruction: must stall two cycles, then issue with the writeback.
  task automatic stall_then_wb(input string name, input logic [31:0] w, input exp_t e,
                               input logic [3:0] r, input logic [31:0] d);
    bus.instr_valid = 1'b1; bus.instr = w;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({name, "_stall"}, bus.instr_ready, 0);
      tick();
    end
    bus.wb_valid = 1'b1; bus.wb_rd = r; bus.wb_data = d;
    @(negedge clk);
    chk({name, "_bypass_accept"}, bus.instr_ready, 1);
    if (bus.instr_ready) q.push_back(e);
    tick();
    bus.instr_valid = 1'b0; bus.wb_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.instr_valid = 1'b0; bus.instr = '0; bus.ex_ready = 1'b1;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
    bus.flag_we = 1'b0; bus.alu_flags = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_instr_ready", bus.instr_ready, 1);
    chk("rst_nzcv", bus.nzcv, 0);
    chk("rst_ex_in1", bus.ex_in1, 0);
    chk("rst_ex_rd", bus.ex_rd, 0);
    tick();

    wb(4'd1, 32'd5);
    wb(4'd2, 32'd7);

    // add r3,r1,r2: one-cycle latency to ex_valid
    send(32'h0003_1200, mk(32'h0003_1200, 4'h0, 32'd5, 32'd7, 1'b1), w);
    chk("add_no_wait", w, 0);
    chk("add_latency_valid", bus.ex_valid, 1);

    // RAW on r3, resolved by writeback bypass
    stall_then_wb("raw", 32'h0104_3100, mk(32'h0104_3100, 4'h1, 32'd12, 32'd5, 1'b1), 4'd3, 32'd12);

    // Backpressure: or r7,r1,r2 held while ex_ready=0
    send(32'h0307_1200, mk(32'h0307_1200, 4'h3, 32'd5, 32'd7, 1'b1), w);
    bus.ex_ready = 1'b0;
    bus.instr_valid = 1'b1; bus.instr = 32'hE5D8_2100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ex_valid", bus.ex_valid, 1);
      chk("bp_opcode", bus.ex_opcode, 4'h3);
      chk("bp_in1", bus.ex_in1, 32'd5);
      chk("bp_in2", bus.ex_in2, 32'd7);
      chk("bp_rd", bus.ex_rd, 4'd7);
      chk("bp_instr_ready", bus.instr_ready, 0);
      tick();
    end
    bus.ex_ready = 1'b1;
    // xor r8,r2,r1 with cond=E, sbit=1, srcontrol=5
    send(32'hE5D8_2100, mk(32'hE5D8_2100, 4'h5, 32'd7, 32'd5, 1'b1), w);
    chk("bp_release_no_wait", w, 0);

    // Undefined opcode -> NOP, no pending bit on r9
    send(32'h0C09_1200, mk(32'h0C09_1200, 4'hF, 32'd5, 32'd7, 1'b0), w);
    send(32'h000A_9900, mk(32'h000A_9900, 4'h0, 32'd0, 32'd0, 1'b1), w);
    chk("undef_no_pending", w, 0);

    // movn ignores source fields even when r0 is pending
    send(32'h0000_1200, mk(32'h0000_1200, 4'h0, 32'd5, 32'd7, 1'b1), w);
    send(32'h0605_BEEF, mk(32'h0605_BEEF, 4'h6, 32'd0, 32'd0, 1'b1), w);
    chk("movn_no_wait", w, 0);
    send(32'h0605_0000, mk(32'h0605_0000, 4'h6, 32'd0, 32'd0, 1'b1), w);
    chk("movn_r0_pending_no_stall", w, 0);

    // Same-cycle set and clear of r6: set wins
    bus.wb_valid = 1'b1; bus.wb_rd = 4'd6; bus.wb_data = 32'd99;
    send(32'h0006_1200, mk(32'h0006_1200, 4'h0, 32'd5, 32'd7, 1'b1), w);
    bus.wb_valid = 1'b0;
    chk("setclr_no_wait", w, 0);
    stall_then_wb("setwins", 32'h030B_6100, mk(32'h030B_6100, 4'h3, 32'd33, 32'd5, 1'b1), 4'd6, 32'd33);

    // Flags
    bus.flag_we = 1'b1; bus.alu_flags = 4'b1001;
    tick();
    bus.flag_we = 1'b0; bus.alu_flags = 4'b0110;
    @(negedge clk);
    chk("nzcv_latch", bus.nzcv, 4'b1001);
    tick();
    @(negedge clk);
    chk("nzcv_hold", bus.nzcv, 4'b1001);
    tick();

    // Reset during a stall on pending r4
    bus.instr_valid = 1'b1; bus.instr = 32'h000C_4100;
    @(negedge clk);
    chk("pre_reset_stall", bus.instr_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("midrst_ex_valid", bus.ex_valid, 0);
    chk("midrst_nzcv", bus.nzcv, 0);
    bus.instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    // r4 and r7 were pending before reset; registers now read zero
    send(32'h000D_4700, mk(32'h000D_4700, 4'h0, 32'd0, 32'd0, 1'b1), w);
    chk("post_reset_no_pending", w, 0);

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
